// File: rtl/sad_min_tracker_pkg.sv
// Shared types and sizing helpers for the SAD minimum tracker.
package me_pkg;

    localparam int ME_MACRO_DIM = 16;
    localparam int ME_MV_W      = 6;

    // Width of one PE column sum: MACRO_DIM bytes of at most 255 each.
    function automatic int col_w(input int dim);
        return $clog2(dim * 255 + 1);
    endfunction

    // Width of a full block SAD: MACRO_DIM*MACRO_DIM bytes of at most 255 each.
    function automatic int sad_w(input int dim);
        return $clog2(dim * dim * 255 + 1);
    endfunction

    typedef enum logic {ME_IDLE, ME_SEARCH} me_state_t;

    // Sideband that travels alongside the column and block sums.
    typedef struct packed {
        logic                       valid;
        logic                       first;
        logic                       last;
        logic signed [ME_MV_W-1:0]  mv_x;
        logic signed [ME_MV_W-1:0]  mv_y;
    } me_side_t;

endpackage

// File: rtl/sad_min_tracker_if.sv
// Candidate input and search-result output bundle of the SAD minimum tracker.
interface sad_min_tracker_if #(
    parameter int MACRO_DIM = me_pkg::ME_MACRO_DIM,
    parameter int MV_W      = me_pkg::ME_MV_W
);
    localparam int SAD_W = me_pkg::sad_w(MACRO_DIM);

    logic                              ad_valid;
    logic                              ad_first;
    logic                              ad_last;
    logic signed [MV_W-1:0]            mv_x;
    logic signed [MV_W-1:0]            mv_y;
    logic [MACRO_DIM*MACRO_DIM*8-1:0]  ad;
    logic                              best_valid;
    logic [SAD_W-1:0]                  best_sad;
    logic signed [MV_W-1:0]            best_mv_x;
    logic signed [MV_W-1:0]            best_mv_y;
    logic                              busy;

    // Candidate source (PE array side).
    modport master (
        output ad_valid, ad_first, ad_last, mv_x, mv_y, ad,
        input  best_valid, best_sad, best_mv_x, best_mv_y, busy
    );

    // The tracker itself.
    modport slave (
        input  ad_valid, ad_first, ad_last, mv_x, mv_y, ad,
        output best_valid, best_sad, best_mv_x, best_mv_y, busy
    );

endinterface

// File: rtl/sad_col_sum.sv
// Combinational sum of one PE column of absolute differences.
module sad_col_sum
    import me_pkg::*;
#(
    parameter  int DIM   = ME_MACRO_DIM,
    localparam int COL_W = col_w(DIM)
) (
    input  logic [DIM*8-1:0]  bytes,
    output logic [COL_W-1:0]  sum
);

    // Zero-extend each byte to the column width so the sum is exact.
    always_comb begin
        sum = '0;
        for (int r = 0; r < DIM; r++) begin
            sum = sum + COL_W'(bytes[8*r +: 8]);
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// Block SAD reduction (column sums -> total) and minimum tracking per search.
// A candidate presented in the cycle that starts at edge N is captured into
// S1 at N+1, reaches S2 at N+2 and updates the min registers at N+3; a last
// candidate makes best_valid high for the cycle after that edge.
// The sideband struct carries ME_MV_W-wide vectors, so MV_W must equal ME_MV_W.
module sad_min_tracker
    import me_pkg::*;
#(
    parameter int MACRO_DIM = ME_MACRO_DIM,
    parameter int MV_W      = ME_MV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    sad_min_tracker_if.slave  bus
);

    localparam int COL_W = col_w(MACRO_DIM);
    localparam int SAD_W = sad_w(MACRO_DIM);

    logic [MACRO_DIM-1:0][COL_W-1:0] col_d;
    logic [MACRO_DIM-1:0][COL_W-1:0] col_q;
    logic [SAD_W-1:0]                sad_d;
    logic [SAD_W-1:0]                sad_q;
    me_side_t                        s1_side;
    me_side_t                        s2_side;

    me_state_t                       state;
    logic [SAD_W-1:0]                min_sad;
    logic signed [MV_W-1:0]          min_mv_x;
    logic signed [MV_W-1:0]          min_mv_y;
    logic                            best_valid_q;

    // One adder per PE column; column c occupies a contiguous slice of ad.
    for (genvar c = 0; c < MACRO_DIM; c++) begin : g_col
        sad_col_sum #(.DIM(MACRO_DIM)) u_col (
            .bytes (bus.ad[c*MACRO_DIM*8 +: MACRO_DIM*8]),
            .sum   (col_d[c])
        );
    end

    // S1: register column sums; bubbles only clear the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_side <= '0;
            col_q   <= '0;
        end else begin
            s1_side.valid <= bus.ad_valid;
            if (bus.ad_valid) begin
                s1_side.first <= bus.ad_first;
                s1_side.last  <= bus.ad_last;
                s1_side.mv_x  <= bus.mv_x;
                s1_side.mv_y  <= bus.mv_y;
                col_q         <= col_d;
            end
        end
    end

    // Second half of the adder tree: fold the column sums into the block SAD.
    always_comb begin
        sad_d = '0;
        for (int c = 0; c < MACRO_DIM; c++) begin
            sad_d = sad_d + SAD_W'(col_q[c]);
        end
    end

    // S2: register the block SAD with its sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_side <= '0;
            sad_q   <= '0;
        end else begin
            s2_side.valid <= s1_side.valid;
            if (s1_side.valid) begin
                s2_side.first <= s1_side.first;
                s2_side.last  <= s1_side.last;
                s2_side.mv_x  <= s1_side.mv_x;
                s2_side.mv_y  <= s1_side.mv_y;
                sad_q         <= sad_d;
            end
        end
    end

    // S3: search FSM and min registers. A first always restarts the search
    // (dropping any open one silently); a non-first outside a search is
    // ignored, including its last flag. Ties keep the earlier candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ME_IDLE;
            min_sad      <= '0;
            min_mv_x     <= '0;
            min_mv_y     <= '0;
            best_valid_q <= 1'b0;
        end else begin
            best_valid_q <= 1'b0;
            if (s2_side.valid) begin
                if (s2_side.first) begin
                    min_sad  <= sad_q;
                    min_mv_x <= s2_side.mv_x;
                    min_mv_y <= s2_side.mv_y;
                    state    <= ME_SEARCH;
                end else if (state == ME_SEARCH && sad_q < min_sad) begin
                    min_sad  <= sad_q;
                    min_mv_x <= s2_side.mv_x;
                    min_mv_y <= s2_side.mv_y;
                end
                if (s2_side.last && (s2_side.first || state == ME_SEARCH)) begin
                    best_valid_q <= 1'b1;
                    state        <= ME_IDLE;
                end
            end
        end
    end

    assign bus.best_valid = best_valid_q;
    assign bus.best_sad   = min_sad;
    assign bus.best_mv_x  = min_mv_x;
    assign bus.best_mv_y  = min_mv_y;
    assign bus.busy       = (state == ME_SEARCH) | s1_side.valid | s2_side.valid;

endmodule
